// File: rtl/tt_leg_pkg.sv
// Shared types and constants for the leg solver.
// Widths are fixed by the tile pinout.
package tt_leg_pkg;

  typedef enum logic [2:0] {
    LOAD,
    SQ,
    DIFF,
    ROOT,
    OUT
  } state_t;

  localparam int OPW   = 8;
  localparam int SQW   = 16;
  localparam int REMW  = 10;
  localparam int ITERS = 8;
  localparam int CW    = $clog2(ITERS);

endpackage

// File: rtl/tt_um_leg_solver_isqrt.sv
// Sequential restoring square root, 2 radicand bits per step.
// The start cycle already performs the first step on d.
module isqrt16_seq
  import tt_leg_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           start,
  input  logic [SQW-1:0] d,
  output logic [OPW-1:0] root,
  output logic           done
);

  logic [SQW-1:0]  rad;
  logic [REMW-1:0] rem;
  logic [OPW-1:0]  root_r;
  logic [CW-1:0]   cnt;
  logic            busy;

  logic [SQW-1:0]  src_rad;
  logic [REMW-1:0] src_rem;
  logic [OPW-1:0]  src_root;
  logic [REMW-1:0] rem_sh;
  logic [REMW-1:0] trial;
  logic            ge;
  logic [REMW-1:0] rem_nx;
  logic [OPW-1:0]  root_nx;

  // One root digit: start restarts from a zero remainder and root.
  always_comb begin
    src_rad  = start ? d : rad;
    src_rem  = start ? '0 : rem;
    src_root = start ? '0 : root_r;
    rem_sh   = {src_rem[REMW-3:0], src_rad[SQW-1:SQW-2]};
    trial    = {src_root, 2'b01};
    ge       = rem_sh >= trial;
    rem_nx   = ge ? rem_sh - trial : rem_sh;
    root_nx  = {src_root[OPW-2:0], ge};
  end

  // Iteration registers; en freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad    <= '0;
      rem    <= '0;
      root_r <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (en) begin
      if (start) begin
        rad    <= {src_rad[SQW-3:0], 2'b00};
        rem    <= rem_nx;
        root_r <= root_nx;
        cnt    <= CW'(1);
        busy   <= 1'b1;
      end else if (busy) begin
        rad    <= {src_rad[SQW-3:0], 2'b00};
        rem    <= rem_nx;
        root_r <= root_nx;
        cnt    <= cnt + CW'(1);
        if (cnt == CW'(ITERS - 1)) busy <= 1'b0;
      end
    end
  end

  assign root = root_r;
  // High while the final digit is being taken.
  assign done = busy && (cnt == CW'(ITERS - 1));

endmodule

// File: rtl/tt_um_leg_solver.sv
// Free-running leg solver: b = floor(sqrt(c*c - a*a)).
// Fixed 19-cycle frame: LOAD, 8x SQ, DIFF, 8x ROOT, OUT.
module tt_um_leg_solver
  import tt_leg_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic [OPW-1:0] ui_in,
  input  logic [OPW-1:0] uio_in,
  output logic [OPW-1:0] uo_out,
  output logic [OPW-1:0] uio_out,
  output logic [OPW-1:0] uio_oe
);

  state_t         state;
  logic [OPW-1:0] c_r;
  logic [OPW-1:0] a_r;
  logic [SQW-1:0] csq;
  logic [SQW-1:0] asq;
  logic [SQW-1:0] d;
  logic           invalid;
  logic [CW-1:0]  cnt;
  logic           start;
  logic [OPW-1:0] uo_r;
  logic [OPW-1:0] root;
  logic           done;

  isqrt16_seq u_root (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ena),
    .start (start),
    .d     (d),
    .root  (root),
    .done  (done)
  );

  // Frame sequencer with shift-add squarers and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOAD;
      c_r     <= '0;
      a_r     <= '0;
      csq     <= '0;
      asq     <= '0;
      d       <= '0;
      invalid <= 1'b0;
      cnt     <= '0;
      start   <= 1'b0;
      uo_r    <= '0;
    end else if (ena) begin
      case (state)
        LOAD: begin
          c_r   <= ui_in;
          a_r   <= uio_in;
          csq   <= '0;
          asq   <= '0;
          cnt   <= '0;
          state <= SQ;
        end
        SQ: begin
          if (c_r[cnt]) csq <= csq + ({8'h00, c_r} << cnt);
          if (a_r[cnt]) asq <= asq + ({8'h00, a_r} << cnt);
          cnt <= cnt + CW'(1);
          if (cnt == CW'(ITERS - 1)) state <= DIFF;
        end
        DIFF: begin
          invalid <= a_r > c_r;
          d       <= (a_r > c_r) ? '0 : csq - asq;
          start   <= 1'b1;
          state   <= ROOT;
        end
        ROOT: begin
          start <= 1'b0;
          if (done) state <= OUT;
        end
        OUT: begin
          uo_r  <= invalid ? '0 : root;
          state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign uo_out  = uo_r;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_leg_solver.sv
// Bench for tt_um_leg_solver: frame-level model plus
// literal expectations per directed frame.
module tb_tt_um_leg_solver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'd0;
  logic [7:0] uio_in = 8'd0;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_chk = 0;
  int n_fail = 0;

  tt_um_leg_solver dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] leg(input int c, input int a);
    int v;
    int r;
    if (a > c) return 8'd0;
    v = c * c - a * a;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return 8'(r);
  endfunction

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame-level model: count enabled edges, sample at phase 0,
  // publish the answer at phase 18.
  int         phase = 0;
  int         pc = 0;
  int         pa = 0;
  logic [7:0] model_out = 8'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0;
      model_out = 8'd0;
    end else if (ena) begin
      if (phase == 0) begin
        pc = int'(ui_in);
        pa = int'(uio_in);
      end
      if (phase == 18) model_out = leg(pc, pa);
      phase = (phase == 18) ? 0 : phase + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) check("model", uo_out, model_out);
    check("uio_out", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'h00);
  end

  logic [7:0] prev_exp = 8'd0;

  task automatic frame(input logic [7:0] c, input logic [7:0] a,
                       input logic [7:0] exp, input bit scr,
                       input bit dis, input string name);
    ui_in  = c;
    uio_in = a;
    for (int i = 0; i < 18; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (scr && (i == 3 || i == 12)) begin
        ui_in  = 8'($urandom);
        uio_in = 8'($urandom);
      end
      if (dis && i == 4) begin
        ena = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("hold", uo_out, prev_exp);
        ena = 1'b1;
      end
    end
    check({name, "_pre"}, uo_out, prev_exp);
    @(posedge clk);
    @(negedge clk);
    check(name, uo_out, exp);
    prev_exp = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    if (leg(5, 3) != 8'd4) begin
      n_fail++;
      $display("FAIL model_pin: got %0d expected 4", leg(5, 3));
    end
    n_chk++;
    repeat (3) @(negedge clk);
    check("reset_uo", uo_out, 8'h00);
    rst_n = 1'b1;
    frame(8'd5, 8'd3, 8'd4, 0, 0, "c5a3");
    frame(8'd13, 8'd5, 8'd12, 0, 0, "c13a5");
    frame(8'd255, 8'd0, 8'd255, 0, 0, "c255a0");
    frame(8'd10, 8'd7, 8'd7, 0, 0, "c10a7");
    frame(8'd200, 8'd200, 8'd0, 0, 0, "a_eq_c");
    frame(8'd3, 8'd5, 8'd0, 0, 0, "a_gt_c");
    frame(8'd25, 8'd7, 8'd24, 0, 0, "c25a7");
    frame(8'd100, 8'd60, 8'd80, 1, 0, "scramble");
    frame(8'd20, 8'd12, 8'd16, 0, 1, "ena_drop");
    ui_in  = 8'd60;
    uio_in = 8'd36;
    repeat (12) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst", uo_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    prev_exp = 8'd0;
    frame(8'd17, 8'd8, 8'd15, 0, 0, "after_rst");
    frame(8'd0, 8'd0, 8'd0, 0, 0, "zero");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
